// File: rtl/shift_add_mul_ctrl_if.sv
// Bus bundle for the shift-and-add multiplier controller.
//
// Groups the request/result handshake and the external adder port pair.
//   start, op_a, op_b         request side (driven by the requester)
//   busy, done, product       result side (driven by the controller)
//   add_a, add_b, add_cin     operands presented to the external W-bit adder
//   add_sum, add_cout         combinational result returned by that adder
//
// Modports:
//   slave  - the multiplier controller
//   master - the requester issuing multiplications
//   adder  - the external combinational ripple adder
interface shift_add_mul_ctrl_if #(
  parameter int W = 8
);
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;

  modport slave (
    input  start, op_a, op_b, add_sum, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );

  modport master (
    output start, op_a, op_b,
    input  busy, done, product
  );

  modport adder (
    input  add_a, add_b, add_cin,
    output add_sum, add_cout
  );
endinterface

// File: rtl/shift_add_mul_ctrl.sv
// Sequential unsigned shift-and-add multiplier controller.
//
// Forms a 2W-bit product of two W-bit operands by time-sharing one external
// combinational W-bit adder over W iterations (one ADD and one SHIFT cycle per
// multiplier bit). This block owns the FSM, the {C,PH,PL} shift register and
// the start/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    shift_add_mul_ctrl_if.slave:
//            start/op_a/op_b  request, sampled only in IDLE
//            busy             high while the FSM is not IDLE
//            done             one-cycle pulse, product valid alongside it
//            product          result register, held until next completion
//            add_a/add_b/add_cin -> external adder, add_sum/add_cout <- adder
//
// Build option:
//   SHIFT_ADD_SKIP_ZERO_EN  skip the ADD cycle for zero multiplier bits;
//                           latency becomes W + popcount(op_b) + 1.
//   Undefined (default)     fixed latency of 2W + 1 cycles.
module shift_add_mul_ctrl #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_mul_ctrl_if.slave   bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   m;
  logic           c;
  logic [W-1:0]   ph;
  logic [W-1:0]   pl;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] product;
  logic           done;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef SHIFT_ADD_SKIP_ZERO_EN
          state_nx = bus.op_b[0] ? ADD : SHIFT;
`else
          state_nx = ADD;
`endif
        end
      end
      ADD: state_nx = SHIFT;
      SHIFT: begin
        if (cnt == LAST) begin
          state_nx = DONE;
        end else begin
`ifdef SHIFT_ADD_SKIP_ZERO_EN
          // pl[1] is the bit that lands in pl[0] once this shift completes.
          state_nx = pl[1] ? ADD : SHIFT;
`else
          state_nx = ADD;
`endif
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      m       <= '0;
      c       <= 1'b0;
      ph      <= '0;
      pl      <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nx;
      // done is registered so it rises together with the product update.
      done  <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            m   <= bus.op_a;
            pl  <= bus.op_b;
            ph  <= '0;
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        ADD: begin
          {c, ph} <= {bus.add_cout, bus.add_sum};
        end
        SHIFT: begin
          // Carry from the last add becomes the new MSB of the high half.
          {c, ph, pl} <= {1'b0, c, ph, pl[W-1:1]};
          if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          product <= {ph, pl};
        end
        default: ;
      endcase
    end
  end

  assign bus.add_a   = (state == ADD) ? ph : '0;
  assign bus.add_b   = ((state == ADD) && pl[0]) ? m : '0;
  assign bus.add_cin = 1'b0;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done;
  assign bus.product = product;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
module tb_shift_add_mul_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;

  shift_add_mul_ctrl_if #(.W(W)) bus ();

  shift_add_mul_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational ripple adder model.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                     + {{W{1'b0}}, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];

  // Passive monitor: counters read later by the directed sequence.
  int   done_cnt = 0;
  int   wide_cnt = 0;
  int   cin_bad  = 0;
  int   idle_add_bad = 0;
  int   addb_nz  = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.done === 1'b1 && done_prev === 1'b1) wide_cnt++;
    done_prev = bus.done;
    if (bus.add_cin !== 1'b0) cin_bad++;
    if (bus.busy === 1'b0 && (bus.add_a !== '0 || bus.add_b !== '0)) idle_add_bad++;
    if (bus.add_b !== '0) addb_nz++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SHIFT_ADD_SKIP_ZERO_EN
    return W + $countones(b) + 1;
`else
    return 2 * W + 1;
`endif
  endfunction

  // Waits (bounded) for done, checks latency/busy span, pops the scoreboard.
  task automatic wait_done(input string tag, input int lat);
    int n;
    int nb;
    bit seen;
    logic [2*W-1:0] e;
    n = 0; nb = 0; seen = 0;
    for (int i = 0; i < 4 * W + 8 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1) nb++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(n - 1), 32'(lat));
      check({tag, "_busy_span"}, 32'(nb), 32'(lat));
      check({tag, "_sb_depth"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({tag, "_product"}, 32'(bus.product), 32'(e));
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
    #1;
    bus.start = 1'b0;
    // Operand changes after acceptance must not matter.
    bus.op_a = W'($urandom);
    bus.op_b = W'($urandom);
    wait_done(tag, exp_lat(b));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int dc0;
    int nz0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_add_a", 32'(bus.add_a), 32'd0);
    check("rst_add_b", 32'(bus.add_b), 32'd0);

    // Basic multiply and full-carry case
    run_op("t1", 8'h0D, 8'h0B);
    check("t1_value", 32'(bus.product), 32'h008F);
    run_op("t2", 8'hFF, 8'hFF);
    check("t2_value", 32'(bus.product), 32'hFE01);

    // Zero multiplier: adder operand B never non-zero
    @(negedge clk);
    nz0 = addb_nz;
    run_op("t3", 8'hA5, 8'h00);
    check("t3_value", 32'(bus.product), 32'h0000);
    check("t3_add_b_zero", 32'(addb_nz - nz0), 32'd0);

    // Back-to-back with start held during busy
    idle_cycles(2);
    dc0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 8'h03;
    bus.op_b  = 8'h05;
    @(posedge clk);
    exp_q.push_back(16'h000F);
    #1;
    bus.op_a = 8'h07;
    bus.op_b = 8'h07;
    wait_done("t4a", exp_lat(8'h05));
    @(posedge clk);
    exp_q.push_back(16'h0031);
    #1 bus.start = 1'b0;
    wait_done("t4b", exp_lat(8'h07));
    check("t4b_value", 32'(bus.product), 32'h0031);
    idle_cycles(2 * W + 4);
    @(posedge clk); #1;
    check("t4_done_pulses", 32'(done_cnt - dc0), 32'd2);
    check("t4_not_busy", 32'(bus.busy), 32'd0);

    // Reset mid-operation
    dc0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 8'h12;
    bus.op_b  = 8'h34;
    @(posedge clk); #1 bus.start = 1'b0;
    idle_cycles(5);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_busy_after_rst", 32'(bus.busy), 32'd0);
    check("t5_product_after_rst", 32'(bus.product), 32'd0);
    idle_cycles(2 * W + 4);
    @(posedge clk); #1;
    check("t5_no_done", 32'(done_cnt - dc0), 32'd0);
    run_op("t5", 8'h12, 8'h34);
    check("t5_value", 32'(bus.product), 32'h03A8);

    // Random operand pairs against reference multiply
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) ra = '0;
      if (i == 1) rb = '1;
      run_op("rnd", ra, rb);
    end

    idle_cycles(3);
    @(posedge clk); #1;
    check("done_width", 32'(wide_cnt), 32'd0);
    check("add_cin_zero", 32'(cin_bad), 32'd0);
    check("adder_idle_zero", 32'(idle_add_bad), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
